// File: rtl/rc4_phase_sched_if.sv
// Bundle between the RC4 phase scheduler, its control host, the three engines and the S memory.
// master = scheduler side, slave = everything around it.
interface rc4_phase_sched_if #(
  parameter int KEY_WIDTH = 24
);
  logic                 start;
  logic [KEY_WIDTH-1:0] key_in;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           phase;
  logic                 init_go;
  logic                 ksa_go;
  logic                 prga_go;
  logic                 restart;
  logic                 init_done;
  logic                 ksa_done;
  logic                 prga_done;
  logic [7:0]           init_addr;
  logic [7:0]           init_wrdata;
  logic                 init_wren;
  logic [7:0]           ksa_addr;
  logic [7:0]           ksa_wrdata;
  logic                 ksa_wren;
  logic [7:0]           prga_addr;
  logic [7:0]           prga_wrdata;
  logic                 prga_wren;
  logic [7:0]           s_addr;
  logic [7:0]           s_wrdata;
  logic                 s_wren;

  modport master (
    input  start, key_in,
    input  init_done, ksa_done, prga_done,
    input  init_addr, init_wrdata, init_wren,
    input  ksa_addr, ksa_wrdata, ksa_wren,
    input  prga_addr, prga_wrdata, prga_wren,
    output key, busy, done, error, phase,
    output init_go, ksa_go, prga_go, restart,
    output s_addr, s_wrdata, s_wren
  );

  modport slave (
    output start, key_in,
    output init_done, ksa_done, prga_done,
    output init_addr, init_wrdata, init_wren,
    output ksa_addr, ksa_wrdata, ksa_wren,
    output prga_addr, prga_wrdata, prga_wren,
    input  key, busy, done, error, phase,
    input  init_go, ksa_go, prga_go, restart,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/rc4_phase_sched.sv
// RC4 sequencer: runs S-init, KSA and PRGA in order, owns the S-memory port,
// guards each phase with a cycle timeout and restarts the engines for a new run.
module rc4_phase_sched #(
  parameter int KEY_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input logic                clk,
  input logic                rst_n,
  rc4_phase_sched_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_GAP1, S_KSA, S_GAP2, S_PRGA, S_DONE, S_RESTART, S_ERR
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 in_phase;
  logic                 timed_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  assign in_phase  = (state_q == S_INIT) || (state_q == S_KSA) || (state_q == S_PRGA);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // Only the current owner's done is looked at; done beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = in_phase ? cnt_q + 16'd1 : 16'd0;
    key_d   = (state_q == S_LOAD) ? bus.key_in : key_q;
    unique case (state_q)
      S_IDLE:    if (bus.start) state_d = S_LOAD;
      S_LOAD:    state_d = S_INIT;
      S_INIT:    if (bus.init_done) state_d = S_GAP1;
                 else if (timed_out) state_d = S_ERR;
      S_GAP1:    state_d = S_KSA;
      S_KSA:     if (bus.ksa_done) state_d = S_GAP2;
                 else if (timed_out) state_d = S_ERR;
      S_GAP2:    state_d = S_PRGA;
      S_PRGA:    if (bus.prga_done) state_d = S_DONE;
                 else if (timed_out) state_d = S_ERR;
      S_DONE,
      S_ERR:     if (bus.start) state_d = S_RESTART;
      S_RESTART: state_d = S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.key      = key_q;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.error    = 1'b0;
    bus.phase    = 2'd0;
    bus.init_go  = 1'b0;
    bus.ksa_go   = 1'b0;
    bus.prga_go  = 1'b0;
    bus.restart  = 1'b0;
    bus.s_addr   = 8'd0;
    bus.s_wrdata = 8'd0;
    bus.s_wren   = 1'b0;
    unique case (state_q)
      S_LOAD: bus.busy = 1'b1;
      S_INIT: begin
        bus.busy     = 1'b1;
        bus.phase    = 2'd1;
        bus.init_go  = 1'b1;
        bus.s_addr   = bus.init_addr;
        bus.s_wrdata = bus.init_wrdata;
        bus.s_wren   = bus.init_wren;
      end
      // Gap states keep the port dead so a finishing engine cannot leak a write.
      S_GAP1: begin
        bus.busy    = 1'b1;
        bus.init_go = 1'b1;
      end
      S_KSA: begin
        bus.busy     = 1'b1;
        bus.phase    = 2'd2;
        bus.init_go  = 1'b1;
        bus.ksa_go   = 1'b1;
        bus.s_addr   = bus.ksa_addr;
        bus.s_wrdata = bus.ksa_wrdata;
        bus.s_wren   = bus.ksa_wren;
      end
      S_GAP2: begin
        bus.busy    = 1'b1;
        bus.init_go = 1'b1;
        bus.ksa_go  = 1'b1;
      end
      S_PRGA: begin
        bus.busy     = 1'b1;
        bus.phase    = 2'd3;
        bus.init_go  = 1'b1;
        bus.ksa_go   = 1'b1;
        bus.prga_go  = 1'b1;
        bus.s_addr   = bus.prga_addr;
        bus.s_wrdata = bus.prga_wrdata;
        bus.s_wren   = bus.prga_wren;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.init_go = 1'b1;
        bus.ksa_go  = 1'b1;
        bus.prga_go = 1'b1;
      end
      S_RESTART: bus.restart = 1'b1;
      S_ERR:     bus.error   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Directed bench for rc4_phase_sched: one instance with the default timeout for
// the full-run scenarios, one with TIMEOUT_CYCLES=16 for the hung-phase case.
module tb_rc4_phase_sched;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  rc4_phase_sched_if #(.KEY_WIDTH(24)) ifa ();
  rc4_phase_sched_if #(.KEY_WIDTH(24)) ifb ();

  rc4_phase_sched #(.KEY_WIDTH(24), .TIMEOUT_CYCLES(8192)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  rc4_phase_sched #(.KEY_WIDTH(24), .TIMEOUT_CYCLES(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_zero(input string pre);
    chk({pre, "_busy"},    ifa.busy,    0);
    chk({pre, "_done"},    ifa.done,    0);
    chk({pre, "_error"},   ifa.error,   0);
    chk({pre, "_phase"},   ifa.phase,   0);
    chk({pre, "_init_go"}, ifa.init_go, 0);
    chk({pre, "_ksa_go"},  ifa.ksa_go,  0);
    chk({pre, "_prga_go"}, ifa.prga_go, 0);
    chk({pre, "_restart"}, ifa.restart, 0);
    chk({pre, "_s_wren"},  ifa.s_wren,  0);
    chk({pre, "_s_addr"},  ifa.s_addr,  0);
    chk({pre, "_s_wrdat"}, ifa.s_wrdata, 0);
    chk({pre, "_key"},     ifa.key,     0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.start = 0; ifa.key_in = '0;
    ifa.init_done = 0; ifa.ksa_done = 0; ifa.prga_done = 0;
    ifa.init_addr = 8'hAA; ifa.init_wrdata = 8'h55; ifa.init_wren = 1;
    ifa.ksa_addr  = 8'h11; ifa.ksa_wrdata  = 8'h22; ifa.ksa_wren  = 1;
    ifa.prga_addr = 8'h33; ifa.prga_wrdata = 8'h44; ifa.prga_wren = 1;
    ifb.start = 0; ifb.key_in = 24'h0000AB;
    ifb.init_done = 0; ifb.ksa_done = 0; ifb.prga_done = 0;
    ifb.init_addr = 8'h66; ifb.init_wrdata = 8'h01; ifb.init_wren = 1;
    ifb.ksa_addr  = 8'h77; ifb.ksa_wrdata  = 8'h02; ifb.ksa_wren  = 1;
    ifb.prga_addr = 8'h88; ifb.prga_wrdata = 8'h03; ifb.prga_wren = 1;

    tick(2);
    rst_n = 1'b1;
    chk_a_zero("reset");

    // Nominal run
    ifa.key_in = 24'h000249;
    ifa.start  = 1;
    tick(1);
    chk("load_busy",  ifa.busy,    1);
    chk("load_phase", ifa.phase,   0);
    chk("load_go",    ifa.init_go, 0);
    ifa.start = 0;
    tick(1);
    chk("init_phase",  ifa.phase,    1);
    chk("init_go",     ifa.init_go,  1);
    chk("init_s_addr", ifa.s_addr,   8'hAA);
    chk("init_s_wdat", ifa.s_wrdata, 8'h55);
    chk("init_s_wren", ifa.s_wren,   1);
    chk("init_key",    ifa.key,      24'h000249);
    tick(255);
    chk("init_wait", ifa.phase, 1);
    ifa.init_done = 1;
    tick(1);
    chk("gap1_phase",  ifa.phase,    0);
    chk("gap1_s_wren", ifa.s_wren,   0);
    chk("gap1_s_addr", ifa.s_addr,   0);
    chk("gap1_s_wdat", ifa.s_wrdata, 0);
    chk("gap1_initgo", ifa.init_go,  1);
    chk("gap1_ksago",  ifa.ksa_go,   0);
    chk("gap1_busy",   ifa.busy,     1);
    tick(1);
    chk("ksa_phase",  ifa.phase,    2);
    chk("ksa_s_addr", ifa.s_addr,   8'h11);
    chk("ksa_s_wdat", ifa.s_wrdata, 8'h22);
    chk("ksa_s_wren", ifa.s_wren,   1);
    chk("ksa_ksago",  ifa.ksa_go,   1);
    chk("ksa_prgago", ifa.prga_go,  0);
    ifa.start = 1;
    tick(1);
    ifa.start = 0;
    chk("ksa_start_ign", ifa.phase,   2);
    chk("ksa_no_rst",    ifa.restart, 0);
    tick(2302);
    chk("ksa_wait", ifa.phase, 2);
    ifa.ksa_done = 1;
    tick(1);
    chk("gap2_phase",  ifa.phase,  0);
    chk("gap2_s_wren", ifa.s_wren, 0);
    chk("gap2_s_addr", ifa.s_addr, 0);
    tick(1);
    chk("prga_phase",  ifa.phase,   3);
    chk("prga_s_addr", ifa.s_addr,  8'h33);
    chk("prga_go",     ifa.prga_go, 1);
    tick(599);
    chk("prga_wait", ifa.phase, 3);
    ifa.prga_done = 1;
    tick(1);
    chk("done_done",   ifa.done,    1);
    chk("done_busy",   ifa.busy,    0);
    chk("done_phase",  ifa.phase,   0);
    chk("done_key",    ifa.key,     24'h000249);
    chk("done_initgo", ifa.init_go, 1);
    chk("done_prgago", ifa.prga_go, 1);
    chk("done_s_wren", ifa.s_wren,  0);
    chk("done_error",  ifa.error,   0);
    tick(5);
    chk("done_hold", ifa.done, 1);

    // Restart from DONE with a new key
    ifa.key_in = 24'h123456;
    ifa.start  = 1;
    tick(1);
    chk("rst_pulse",  ifa.restart, 1);
    chk("rst_busy",   ifa.busy,    0);
    chk("rst_go",     ifa.init_go, 0);
    chk("rst_done",   ifa.done,    0);
    ifa.start = 0;
    ifa.init_done = 0; ifa.ksa_done = 0; ifa.prga_done = 0;
    tick(1);
    chk("rl_restart", ifa.restart, 0);
    chk("rl_busy",    ifa.busy,    1);
    chk("rl_key_old", ifa.key,     24'h000249);
    tick(1);
    chk("r_init_key",   ifa.key,   24'h123456);
    chk("r_init_phase", ifa.phase, 1);
    ifa.init_done = 1;
    tick(2);
    chk("r_ksa_phase", ifa.phase, 2);

    // Reset mid-KSA, stale prga_done held from here on
    rst_n = 1'b0;
    ifa.init_done = 0;
    ifa.prga_done = 1;
    tick(1);
    rst_n = 1'b1;
    chk_a_zero("midrst");

    ifa.start = 1;
    tick(1);
    ifa.start = 0;
    tick(1);
    chk("fresh_init", ifa.phase, 1);
    tick(10);
    chk("stale_init_wait", ifa.phase, 1);
    ifa.init_done = 1;
    tick(2);
    chk("fresh_ksa", ifa.phase, 2);
    tick(10);
    chk("stale_ksa_wait", ifa.phase, 2);
    ifa.ksa_done = 1;
    tick(1);
    chk("fresh_gap2", ifa.phase, 0);
    tick(1);
    chk("fresh_prga", ifa.phase, 3);
    tick(1);
    chk("stale_prga_exit", ifa.done,  1);
    chk("stale_prga_ph",   ifa.phase, 0);

    // Hung KSA on the short-timeout instance
    ifb.start = 1;
    tick(1);
    ifb.start = 0;
    tick(1);
    chk("to_init", ifb.phase, 1);
    ifb.init_done = 1;
    tick(2);
    chk("to_ksa",     ifb.phase,  2);
    chk("to_ksa_wr",  ifb.s_wren, 1);
    tick(15);
    chk("to_ksa_last", ifb.phase, 2);
    chk("to_no_err",   ifb.error, 0);
    tick(1);
    chk("to_error",   ifb.error,   1);
    chk("to_initgo",  ifb.init_go, 0);
    chk("to_ksago",   ifb.ksa_go,  0);
    chk("to_prgago",  ifb.prga_go, 0);
    chk("to_s_wren",  ifb.s_wren,  0);
    chk("to_busy",    ifb.busy,    0);
    chk("to_phase",   ifb.phase,   0);
    tick(3);
    chk("to_err_hold", ifb.error, 1);
    ifb.start = 1;
    tick(1);
    chk("to_restart", ifb.restart, 1);
    chk("to_rs_err",  ifb.error,   0);
    ifb.start = 0;
    tick(1);
    chk("to_load_rst",  ifb.restart, 0);
    chk("to_load_busy", ifb.busy,    1);
    chk("to_load_ph",   ifb.phase,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_phase_sched.md
# rc4_phase_sched

Sequencer and S-memory arbiter for the RC4 datapath. It owns the single-port 256x8 S memory and runs the three engines in order: S-init, key-schedule swap loop and PRGA/decrypt. It latches the key, raises each engine's enable level, switches memory ownership on each done flag, watches for hung phases, and pulses a restart to all engines for a new run.

## Interface
- Parameter `KEY_WIDTH`, default 24. Key width in bits.
- Parameter `TIMEOUT_CYCLES`, default 8192. Per-phase cycle limit; 0 disables the timeout.
- `clk` in 1. Single clock.
- `rst_n` in 1. Reset, synchronous and active-low.
- `start` in 1. Request a run; sampled only in IDLE, DONE and ERR.
- `key_in` in KEY_WIDTH. Key, captured in LOAD.
- `key` out KEY_WIDTH. Latched key, fed to the engines.
- `busy` out 1. High from LOAD through PRGA, including gap states.
- `done` out 1. High in DONE.
- `error` out 1. High in ERR.
- `phase` out 2. Current memory owner: 0 none, 1 init, 2 ksa, 3 prga.
- `init_go`, `ksa_go`, `prga_go` out 1 each. Engine enable levels.
- `restart` out 1. One-cycle pulse telling the engines to return to their start state.
- `init_done`, `ksa_done`, `prga_done` in 1 each. Engine done flags, level, sticky.
- `init_addr`/`init_wrdata` in 8 and `init_wren` in 1. Same triple for `ksa_*` and `prga_*`. Engine memory requests.
- `s_addr` out 8, `s_wrdata` out 8, `s_wren` out 1. To the S memory. Read data goes straight from memory to the engines and does not pass through this block.

## Operation
- States: IDLE, LOAD, INIT, GAP1, KSA, GAP2, PRGA, DONE, RESTART, ERR.
- IDLE → LOAD when `start`=1.
- LOAD: `key` <= `key_in`, then → INIT.
- INIT → GAP1 when `init_done`=1.
- GAP1 → KSA unconditionally.
- KSA → GAP2 when `ksa_done`=1.
- GAP2 → PRGA unconditionally.
- PRGA → DONE when `prga_done`=1.
- DONE or ERR → RESTART when `start`=1; otherwise hold.
- RESTART → LOAD. `restart`=1 only in this state.
- `start` in any other state is ignored; it is not queued.
- Go levels are sticky for a run:
  - `init_go`=1 in INIT..DONE.
  - `ksa_go`=1 in KSA..DONE.
  - `prga_go`=1 in PRGA..DONE.
  - All go levels are 0 in IDLE, LOAD, RESTART and ERR.
  - Engines freeze, not reset, when their go drops.
- Memory mux:
  - Combinational from the registered state.
  - INIT passes the `init_*` triple; KSA passes `ksa_*`; PRGA passes `prga_*`.
  - All other states, including GAP1 and GAP2, drive `s_addr`=0, `s_wrdata`=0, `s_wren`=0. This blocks a stray write from the finishing engine.
- A done input from a phase that does not currently own memory is ignored.
- Timeout counter (16-bit):
  - Cleared on entry to INIT, KSA and PRGA; increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 with the owner's done still 0 → ERR.
  - If done and the timeout coincide in the same cycle, done wins.
- `phase` decodes from state: 1, 2 or 3 in INIT, KSA or PRGA; 0 elsewhere.
- `busy`, `done`, `error` and `phase` are Moore outputs, decoded from the state register.

## Timing
- Reset (`rst_n`=0 at a clk edge, from any state, including mid-phase):
  - State → IDLE; counter=0; `key`=0.
  - All outputs 0 on the next edge: `busy`, `done`, `error`, `phase`, all go levels, `restart`, `s_wren`.
  - `s_addr` and `s_wrdata` are 0 as well.
- `start` high at edge t in IDLE: LOAD at t+1, INIT at t+2. `init_go` and owner=init are visible after t+2.
- Done sampled high at edge t in INIT: GAP1 at t+1, KSA at t+2. Handoff costs exactly one dead cycle with `s_wren`=0.
- Mux latency is zero: the engine's request appears on `s_*` in the same cycle.
- `restart` pulse width is exactly 1 cycle. `key` is reloaded one cycle later, in LOAD.

## Test plan
- Nominal run: reset, `key_in`=24'h000249, `start` pulse. Stub engines assert done after 256, 2304 and 600 cycles. Expect:
  - `phase` sequence 1,0,2,0,3,0.
  - `done`=1 and `busy`=0 after PRGA.
  - `key`=24'h000249.
- Mux isolation: init stub drives `init_wren`=1 and `init_addr`=8'hAA continuously.
  - During KSA, `s_addr` must equal `ksa_addr`.
  - In GAP1, `s_wren`=0 and `s_addr`=0.
- Stale done: hold `prga_done`=1 from reset.
  - INIT and KSA still wait on their own done.
  - PRGA exits one cycle after entry.
- Timeout: TIMEOUT_CYCLES=16 and `ksa_done` never asserts.
  - ERR entered 16 cycles after KSA entry: `error`=1, all go levels 0, `s_wren`=0.
  - Then `start` → one-cycle `restart` → LOAD.
- Restart: in DONE, `start` with `key_in`=24'h123456.
  - `restart` high for 1 cycle, then LOAD; `key`=24'h123456 one cycle later.
  - `start` pulses during KSA are ignored.
- Reset mid-KSA: drop `rst_n` for 1 cycle.
  - Next cycle: IDLE, every output 0, `key`=0.
  - A fresh `start` runs the full sequence.
